regfile_mp: RTL and testbench

Parametrised multi-port register file for the CPU core: the successor to the single-write, dual-read 32×32 file, with configurable read and write port counts and a per-register busy scoreboard. After reset, a sequencer clears the storage array one entry per cycle, so the array needs no reset flops. It sits between decode (read ports, issue) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_if.sv | 22 ++
 rtl/regfile_scoreboard.sv | 34 +++
 rtl/regfile_mp.sv | 131 +++++++++++++
 tb/tb_regfile_mp.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

    localparam int MAX_PORTS = 16;
    localparam int PIDX_W    = 4;

    typedef struct packed {
        logic              hit;
        logic [PIDX_W-1:0] idx;
    } port_sel_t;

    // Highest-index set bit of a port match vector; the last port wins on conflicts.
    function automatic port_sel_t hi_match(input logic [MAX_PORTS-1:0] m);
        hi_match = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (m[i]) begin
                hi_match.hit = 1'b1;
                hi_match.idx = i[PIDX_W-1:0];
            end
        end
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bus of the multi-port register file.
interface regfile_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2,
    parameter int NWRITE     = 2
);
    logic [NWRITE-1:0]            wen;
    logic [NWRITE*ADDR_WIDTH-1:0] waddr;
    logic [NWRITE*DATA_WIDTH-1:0] wdata;
    logic [NREAD*ADDR_WIDTH-1:0]  raddr;
    logic [NREAD*DATA_WIDTH-1:0]  rdata;
    logic [NREAD-1:0]             rbusy;
    logic                         issue_en;
    logic [ADDR_WIDTH-1:0]        issue_addr;
    logic                         ready;

    modport master (output wen, waddr, wdata, raddr, issue_en, issue_addr,
                    input  rdata, rbusy, ready);
    modport slave  (input  wen, waddr, wdata, raddr, issue_en, issue_addr,
                    output rdata, rbusy, ready);
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by issue, cleared by writeback, read per read port.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int NREAD      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ready_i,
    input  logic [DEPTH-1:0]            set_i,
    input  logic [DEPTH-1:0]            clr_i,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr_i,
    input  logic [NREAD-1:0]            rmask_i,
    output logic [NREAD-1:0]            rbusy_o
);
    logic [DEPTH-1:0] busy_q, busy_d;

    // Set is applied after clear so an issue wins over a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        if (ready_i) busy_d = (busy_q & ~clr_i) | set_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    for (genvar r = 0; r < NREAD; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra         = raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign rbusy_o[r] = ready_i & busy_q[ra] & ~rmask_i[r];
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sequencer and busy scoreboard.
// Optional same-cycle write-to-read forwarding is built when RF_BYPASS_EN is defined.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2,
    parameter int NWRITE     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_we, run;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] waddr_a [NWRITE];
    logic [DATA_WIDTH-1:0] wdata_a [MAX_PORTS];
    logic [NWRITE-1:0]     wen_eff;
    logic                  issue_ok;

    logic [MAX_PORTS-1:0]  wm   [DEPTH];
    port_sel_t             wsel [DEPTH];
    logic [DEPTH-1:0]      set_v, clr_v;
    logic [NREAD-1:0]      rmask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter wraps to zero on the way into RF_RUN and then stays put.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            RF_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) state_d = RF_RUN;
            end
            RF_RUN:  ;
            default: state_d = RF_INIT;
        endcase
    end

    assign run       = (state_q == RF_RUN);
    assign bus.ready = run;
    assign issue_ok  = run & bus.issue_en & ~(ZR && (bus.issue_addr == '0));

    for (genvar i = 0; i < MAX_PORTS; i++) begin : g_wport
        if (i < NWRITE) begin : g_on
            assign waddr_a[i] = bus.waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_a[i] = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
            assign wen_eff[i] = run & bus.wen[i] & ~(ZR && (waddr_a[i] == '0));
        end else begin : g_off
            assign wdata_a[i] = '0;
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            wm[e] = '0;
            for (int i = 0; i < NWRITE; i++)
                wm[e][i] = wen_eff[i] && (waddr_a[i] == ADDR_WIDTH'(e));
            wsel[e]  = hi_match(wm[e]);
            clr_v[e] = wsel[e].hit;
            set_v[e] = issue_ok && (bus.issue_addr == ADDR_WIDTH'(e));
        end
    end

    // Storage has no reset; the clear sequencer zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (init_we) mem_q[cnt_q] <= '0;
        for (int e = 0; e < DEPTH; e++)
            if (wsel[e].hit) mem_q[e] <= wdata_a[wsel[e].idx];
    end

    for (genvar r = 0; r < NREAD; r++) begin : g_rport
        logic [ADDR_WIDTH-1:0] ra;
        logic                  zhit;
        logic [DATA_WIDTH-1:0] rd;
        assign ra   = bus.raddr[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign zhit = ZR && (ra == '0);
`ifdef RF_BYPASS_EN
        logic [MAX_PORTS-1:0] rm;
        port_sel_t            rsel;
        always_comb begin
            rm = '0;
            for (int i = 0; i < NWRITE; i++)
                rm[i] = wen_eff[i] && (waddr_a[i] == ra);
            rsel = hi_match(rm);
        end
        assign rd       = zhit ? '0 : (rsel.hit ? wdata_a[rsel.idx] : mem_q[ra]);
        assign rmask[r] = zhit | (rsel.hit & ~(issue_ok && (bus.issue_addr == ra)));
`else
        assign rd       = zhit ? '0 : mem_q[ra];
        assign rmask[r] = zhit;
`endif
        assign bus.rdata[r*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .NREAD      (NREAD)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .ready_i (run),
        .set_i   (set_v),
        .clr_i   (clr_v),
        .raddr_i (bus.raddr),
        .rmask_i (rmask),
        .rbusy_o (bus.rbusy)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomised checks of regfile_mp with 3 read and 2 write ports.
module tb_regfile_mp;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    regfile_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(3), .NWRITE(2)) bus ();

    regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(3), .NWRITE(2), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.wen        = '0;
        bus.waddr      = '0;
        bus.wdata      = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
    endtask

    task automatic setw(input int p, input logic [4:0] a, input logic [31:0] d);
        bus.wen[p]           = 1'b1;
        bus.waddr[p*5 +: 5]  = a;
        bus.wdata[p*32 +: 32] = d;
    endtask

    task automatic setr(input int r, input logic [4:0] a);
        bus.raddr[r*5 +: 5] = a;
    endtask

    task automatic seti(input logic [4:0] a);
        bus.issue_en   = 1'b1;
        bus.issue_addr = a;
    endtask

    function automatic logic [31:0] rd(input int r);
        return bus.rdata[r*32 +: 32];
    endfunction

    // ready must be low after edges 1..31 and high after edge 32
    task automatic count_init(input string tag);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            checks++;
            if (bus.ready !== (k == 32)) begin
                errors++;
                $display("FAIL %s_ready edge %0d: got %b expected %b", tag, k, bus.ready, (k == 32));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.raddr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready);
        end
        checks++;
        if (bus.rbusy !== 3'b000) begin
            errors++; $display("FAIL reset_rbusy: got %b expected 000", bus.rbusy);
        end
        rst = 1'b0;
        setw(0, 5'd5, 32'hDEAD);
        seti(5'd5);
        count_init("init");
        idle();
        setr(0, 5'd5);
        #1;
        checks++;
        if (rd(0) !== 32'h0) begin
            errors++; $display("FAIL init_write_ignored: got %h expected 0", rd(0));
        end
        checks++;
        if (bus.rbusy[0] !== 1'b0) begin
            errors++; $display("FAIL init_issue_ignored: got %b expected 0", bus.rbusy[0]);
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        idle();
        setw(0, 5'd7, 32'h11);
        setw(1, 5'd7, 32'h22);
        setr(0, 5'd7);
        setr(2, 5'd7);
        #1;
        checks++;
`ifdef RF_BYPASS_EN
        if (rd(0) !== 32'h22) begin
            errors++; $display("FAIL same_addr_bypass: got %h expected 22", rd(0));
        end
`else
        if (rd(0) !== 32'h0) begin
            errors++; $display("FAIL same_addr_old: got %h expected 0", rd(0));
        end
`endif
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rd(0) !== 32'h22) begin
            errors++; $display("FAIL same_addr_p0: got %h expected 22", rd(0));
        end
        checks++;
        if (rd(2) !== 32'h22) begin
            errors++; $display("FAIL same_addr_p2: got %h expected 22", rd(2));
        end
        setw(0, 5'd0, 32'hFFFF_FFFF);
        setr(1, 5'd0);
        #1;
        checks++;
        if (rd(1) !== 32'h0) begin
            errors++; $display("FAIL zero_same_cycle: got %h expected 0", rd(1));
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rd(1) !== 32'h0) begin
            errors++; $display("FAIL zero_reg: got %h expected 0", rd(1));
        end
    endtask

    task automatic test_busy();
        @(negedge clk);
        idle();
        seti(5'd3);
        setr(0, 5'd3);
        #1;
        checks++;
        if (bus.rbusy[0] !== 1'b0) begin
            errors++; $display("FAIL busy_not_yet: got %b expected 0", bus.rbusy[0]);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.rbusy[0] !== 1'b1) begin
            errors++; $display("FAIL busy_set: got %b expected 1", bus.rbusy[0]);
        end
        setw(0, 5'd3, 32'h33);
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.rbusy[0] !== 1'b0) begin
            errors++; $display("FAIL busy_clear: got %b expected 0", bus.rbusy[0]);
        end
        checks++;
        if (rd(0) !== 32'h33) begin
            errors++; $display("FAIL busy_wdata: got %h expected 33", rd(0));
        end
        seti(5'd3);
        setw(1, 5'd3, 32'h55);
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.rbusy[0] !== 1'b1) begin
            errors++; $display("FAIL issue_wins: got %b expected 1", bus.rbusy[0]);
        end
        checks++;
        if (rd(0) !== 32'h55) begin
            errors++; $display("FAIL issue_write_data: got %h expected 55", rd(0));
        end
        seti(5'd0);
        setr(1, 5'd0);
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.rbusy[1] !== 1'b0) begin
            errors++; $display("FAIL zero_never_busy: got %b expected 0", bus.rbusy[1]);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        seti(5'd9);
        setw(0, 5'd9, 32'h1234);
        @(negedge clk);
        idle();
        setw(1, 5'd9, 32'hCAFE);
        setr(1, 5'd9);
        #1;
        checks += 2;
`ifdef RF_BYPASS_EN
        if (rd(1) !== 32'hCAFE) begin
            errors++; $display("FAIL bypass_data: got %h expected cafe", rd(1));
        end
        if (bus.rbusy[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_busy: got %b expected 0", bus.rbusy[1]);
        end
`else
        if (rd(1) !== 32'h1234) begin
            errors++; $display("FAIL nobypass_data: got %h expected 1234", rd(1));
        end
        if (bus.rbusy[1] !== 1'b1) begin
            errors++; $display("FAIL nobypass_busy: got %b expected 1", bus.rbusy[1]);
        end
`endif
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rd(1) !== 32'hCAFE) begin
            errors++; $display("FAIL bypass_next: got %h expected cafe", rd(1));
        end
        checks++;
        if (bus.rbusy[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_next_busy: got %b expected 0", bus.rbusy[1]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        setw(0, 5'd4, 32'h44);
        seti(5'd12);
        setr(0, 5'd4);
        setr(2, 5'd12);
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rd(0) !== 32'h44) begin
            errors++; $display("FAIL mid_pre_data: got %h expected 44", rd(0));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready_drop: got %b expected 0", bus.ready);
        end
        @(negedge clk);
        rst = 1'b0;
        count_init("rerun");
        #1;
        checks++;
        if (rd(0) !== 32'h0) begin
            errors++; $display("FAIL mid_cleared: got %h expected 0", rd(0));
        end
        checks++;
        if (bus.rbusy[2] !== 1'b0) begin
            errors++; $display("FAIL mid_busy_cleared: got %b expected 0", bus.rbusy[2]);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_mem [32];
        logic        m_busy [32];
        logic [1:0]  w_en;
        logic [4:0]  w_a [2];
        logic [31:0] w_d [2];
        logic        i_en;
        logic [4:0]  i_a;
        logic [4:0]  r_a;
        logic [31:0] exp_d;
        logic        exp_b;
        logic        hit;
        logic [31:0] hd;
        for (int e = 0; e < 32; e++) begin
            m_mem[e]  = '0;
            m_busy[e] = 1'b0;
        end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            idle();
            for (int p = 0; p < 2; p++) begin
                w_en[p] = 1'($urandom_range(0, 1));
                w_a[p]  = 5'($urandom_range(0, 7));
                w_d[p]  = $urandom;
                if (w_en[p]) setw(p, w_a[p], w_d[p]);
            end
            i_en = 1'($urandom_range(0, 1));
            i_a  = 5'($urandom_range(0, 7));
            if (i_en) seti(i_a);
            for (int r = 0; r < 3; r++) setr(r, 5'($urandom_range(0, 7)));
            #1;
            for (int r = 0; r < 3; r++) begin
                r_a = bus.raddr[r*5 +: 5];
                hit = 1'b0;
                hd  = '0;
                for (int p = 0; p < 2; p++)
                    if (w_en[p] && w_a[p] == r_a) begin hit = 1'b1; hd = w_d[p]; end
                exp_d = m_mem[r_a];
                exp_b = m_busy[r_a];
`ifdef RF_BYPASS_EN
                if (hit) exp_d = hd;
                if (hit && !(i_en && i_a == r_a)) exp_b = 1'b0;
`endif
                if (r_a == 5'd0) begin exp_d = '0; exp_b = 1'b0; end
                checks++;
                if (rd(r) !== exp_d) begin
                    errors++; $display("FAIL rand_data n=%0d port=%0d addr=%0d: got %h expected %h", n, r, r_a, rd(r), exp_d);
                end
                checks++;
                if (bus.rbusy[r] !== exp_b) begin
                    errors++; $display("FAIL rand_busy n=%0d port=%0d addr=%0d: got %b expected %b", n, r, r_a, bus.rbusy[r], exp_b);
                end
            end
            for (int p = 0; p < 2; p++)
                if (w_en[p] && w_a[p] != 5'd0) begin
                    m_mem[w_a[p]]  = w_d[p];
                    m_busy[w_a[p]] = 1'b0;
                end
            if (i_en && i_a != 5'd0) m_busy[i_a] = 1'b1;
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_same_addr();
        test_busy();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
